// File: rtl/hs_pkg.sv
// Shared types and constants for the handshake receive side.
package hs_pkg;

  localparam int unsigned RX_SYNC_MIN = 2;

  typedef enum logic [1:0] {
    RESYNC     = 2'd0,
    IDLE       = 2'd1,
    WAIT_SPACE = 2'd2,
    ACK        = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_ff_m.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_ff_m #(
  parameter int unsigned STAGES = 2
) (
  input  logic aclk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge aclk) begin
    if (!reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/hs_sync_rx_m.sv
// 4-phase bundled-data receiver: synchronises in_req, captures in_data into a
// small FIFO, returns in_ack and presents words on a valid/ready interface.
module hs_sync_rx_m
  import hs_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic                         in_req,
  output logic                         in_ack,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < RX_SYNC_MIN) ? RX_SYNC_MIN : SYNC_STAGES;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic              w_req_s;
  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic              r_ack;
  logic              w_ack_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [SYNC_N-1:0] r_settle;
  logic              r_armed;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  sync_ff_m #(.STAGES(SYNC_N)) u_req_sync (
    .aclk  (aclk),
    .reset (reset),
    .d     (in_req),
    .q     (w_req_s)
  );

  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign count     = r_count;
  assign in_ack    = r_ack;

  // Handshake sequencing; a capture needs r_armed, i.e. a genuinely low request
  // seen after the synchroniser has refilled, since its reset zeros look "low".
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      RESYNC: begin
        if (!w_req_s) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_req_s && r_armed) begin
          if (!w_full) begin
            w_push      = 1'b1;
            w_ack_nxt   = 1'b1;
            w_state_nxt = ACK;
          end else begin
            w_state_nxt = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        if (w_req_s) begin
          w_ack_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = RESYNC;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!reset) begin
      r_state  <= RESYNC;
      r_ack    <= 1'b0;
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ack    <= w_ack_nxt;
      r_settle <= {r_settle[SYNC_N-2:0], 1'b1};
      r_armed  <= r_armed | (r_settle[SYNC_N-1] & ~w_req_s);
    end
  end

  // FIFO storage, wrap-bit pointers and occupancy.
  always_ff @(posedge aclk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_sync_rx_m.sv
// Directed bench for hs_sync_rx_m with hand-computed expectations.
module tb_hs_sync_rx_m;
  import hs_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic             aclk = 1'b0;
  logic             reset;
  logic             in_req;
  logic             in_ack;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int n_vec    = 0;
  int n_err    = 0;
  int wrap_idx = 0;
  bit mon_en   = 1'b0;

  always #5 aclk = ~aclk;

  hs_sync_rx_m #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .aclk      (aclk),
    .reset     (reset),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge aclk);
  endtask

  task automatic wait_ack(input logic lvl);
    int k = 0;
    while (in_ack !== lvl && k < 16) begin
      tick();
      k++;
    end
  endtask

  task automatic hs(input logic [31:0] d, input string tag);
    in_data = d;
    in_req  = 1'b1;
    wait_ack(1'b1);
    chk({tag, "_ack_hi"}, 32'(in_ack), 32'd1);
    in_req = 1'b0;
    wait_ack(1'b0);
    chk({tag, "_ack_lo"}, 32'(in_ack), 32'd0);
  endtask

  // Observes each word as it is popped during the wrap-around phase.
  always @(negedge aclk) begin
    if (mon_en && out_valid) begin
      chk("wrap_data", out_data, 32'(32'hA0 + wrap_idx));
      chk("wrap_cnt_le1", 32'(count <= 1), 32'd1);
      wrap_idx++;
    end
  end

  initial begin
    reset     = 1'b0;
    in_req    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (3) begin
      tick();
      chk("rst_ack",   32'(in_ack),    32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count),     32'd0);
      chk("rst_data",  out_data,       32'd0);
    end
    reset = 1'b1;
    tick();
    chk("rst_state_idle", 32'(dut.r_state), 32'(IDLE));
    chk("rst_rel_ack", 32'(in_ack), 32'd0);
    tick(3);

    in_data = 32'hDEADBEEF;
    in_req  = 1'b1;
    tick(2);
    chk("single_ack_early", 32'(in_ack), 32'd0);
    chk("single_valid_early", 32'(out_valid), 32'd0);
    tick();
    chk("single_ack", 32'(in_ack), 32'd1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'hDEADBEEF);
    chk("single_count", 32'(count), 32'd1);
    in_req = 1'b0;
    tick(2);
    chk("single_ack_hold", 32'(in_ack), 32'd1);
    tick();
    chk("single_ack_fall", 32'(in_ack), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_count", 32'(count), 32'd0);
    chk("single_pop_valid", 32'(out_valid), 32'd0);

    for (int d = 1; d <= 4; d++) hs(32'(d), "fill");
    chk("full_count", 32'(count), 32'd4);
    in_data = 32'd5;
    in_req  = 1'b1;
    tick(6);
    chk("stall_ack", 32'(in_ack), 32'd0);
    chk("stall_count", 32'(count), 32'd4);
    chk("stall_state", 32'(dut.r_state), 32'(WAIT_SPACE));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("popush_count", 32'(count), 32'd3);
    chk("popush_ack", 32'(in_ack), 32'd0);
    chk("popush_head", out_data, 32'd2);
    tick();
    chk("popush_refill", 32'(count), 32'd4);
    chk("popush_ack_late", 32'(in_ack), 32'd1);
    in_req = 1'b0;
    wait_ack(1'b0);
    chk("stall_ack_lo", 32'(in_ack), 32'd0);
    for (int d = 2; d <= 5; d++) begin
      chk("drain_data", out_data, 32'(d));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("drain_count", 32'(count), 32'd0);

    out_ready = 1'b1;
    mon_en    = 1'b1;
    for (int i = 0; i < 10; i++) hs(32'(32'hA0 + i), "wrap");
    tick(4);
    mon_en    = 1'b0;
    out_ready = 1'b0;
    chk("wrap_words", 32'(wrap_idx), 32'd10);
    chk("wrap_count", 32'(count), 32'd0);

    hs(32'h11, "mr_first");
    in_data = 32'h22;
    in_req  = 1'b1;
    wait_ack(1'b1);
    chk("mr_pre_ack", 32'(in_ack), 32'd1);
    chk("mr_pre_count", 32'(count), 32'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mr_ack", 32'(in_ack), 32'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_data", out_data, 32'd0);
    repeat (6) begin
      tick();
      chk("mr_hold_ack", 32'(in_ack), 32'd0);
      chk("mr_hold_count", 32'(count), 32'd0);
    end
    in_req = 1'b0;
    tick(4);
    chk("mr_idle_count", 32'(count), 32'd0);
    in_data = 32'h55;
    in_req  = 1'b1;
    wait_ack(1'b1);
    chk("post_ack_hi", 32'(in_ack), 32'd1);
    chk("post_count", 32'(count), 32'd1);
    chk("post_data", out_data, 32'h55);
    in_req = 1'b0;
    wait_ack(1'b0);
    chk("post_ack_lo", 32'(in_ack), 32'd0);
    chk("post_count_once", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_pop_count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
